// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// FSM state encoding, default width and the majority helper.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic maj3(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational full-adder cell.
// Ports: a_i, b_i, cin_i in; s_o sum, c_o carry out.
module fa_bit
  import serial_adder_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ cin_i;
  assign c_o = maj3(a_i, b_i, cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, registered carry.
// Ports: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out, busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;

  logic st_idle, st_run, st_done;
  logic s_bit, c_next;

  assign st_idle = (state_q == S_IDLE);
  assign st_run  = (state_q == S_RUN);
  assign st_done = (state_q == S_DONE);

  fa_bit u_fa (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .cin_i (carry_q),
    .s_o   (s_bit),
    .c_o   (c_next)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    ov_d     = ov_q;
    unique case (1'b1)
      st_idle: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = S_RUN;
        end
      end
      st_run: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = c_next;
        // new sum bit enters at the MSB end
        sum_sr_d = sum_sr_q >> 1;
        sum_sr_d[WIDTH-1] = s_bit;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          ov_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      st_done: begin
        if (out_ready) begin
          state_d = S_IDLE;
          ov_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ov_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
    end
  end

  assign in_ready  = st_idle;
  assign busy      = st_run | st_done;
  assign out_valid = ov_q;
  assign sum       = sum_sr_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Random and directed operands against an arithmetic reference.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       iv, ir, ov, ordy, co, bz;
  logic [7:0] a, b, s;
  logic       c;

  logic       iv1, ir1, ov1, ordy1, co1, bz1;
  logic [0:0] a1, b1, s1;
  logic       c1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv),
    .in_ready  (ir),
    .a         (a),
    .b         (b),
    .cin       (c),
    .out_valid (ov),
    .out_ready (ordy),
    .sum       (s),
    .cout      (co),
    .busy      (bz)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (ir1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .out_valid (ov1),
    .out_ready (ordy1),
    .sum       (s1),
    .cout      (co1),
    .busy      (bz1)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand set, check latency and result.
  task automatic op8(
    input logic [7:0] xa,
    input logic [7:0] xb,
    input logic       xc,
    input string      tag
  );
    int n;
    logic [8:0] exp;
    exp = 9'(xa) + 9'(xb) + 9'(xc);
    chk({tag, ".rdy"}, 64'(ir), 64'd1);
    iv = 1'b1; a = xa; b = xb; c = xc;
    tick();
    iv = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
    chk({tag, ".busy"}, 64'({ir, bz}), 64'b01);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ov && n < 20);
    chk({tag, ".lat"}, 64'(n), 64'd8);
    chk({tag, ".res"}, 64'({co, s}), 64'(exp));
    if (ordy) begin
      tick();
      chk({tag, ".drop"}, 64'({ov, ir}), 64'b01);
    end
  endtask

  initial begin
    logic [7:0] hs;
    logic       hc;
    logic [8:0] q[$];
    logic [8:0] e;
    int got, last, cyc;

    rst_n = 1'b0;
    iv = 0; a = 0; b = 0; c = 0; ordy = 1;
    iv1 = 0; a1 = 0; b1 = 0; c1 = 0; ordy1 = 1;
    #3;
    chk("rst.outs", 64'({ov, s, co, bz, ir}), 64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
    #9 rst_n = 1'b1;
    tick();

    op8(8'h5A, 8'h3C, 1'b0, "t1");
    op8(8'hFF, 8'h01, 1'b0, "t2a");
    op8(8'hFF, 8'hFF, 1'b1, "t2b");
    op8(8'h00, 8'h00, 1'b1, "t2c");

    // backpressure with ignored input pulse
    ordy = 1'b0;
    op8(8'h22, 8'h33, 1'b0, "t3");
    hs = s; hc = co;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        iv = 1'b1; a = 8'h11; b = 8'h00; c = 1'b0;
      end
      tick();
      iv = 1'b0;
      chk("t3.hold", 64'({ov, ir, s, co}), 64'({1'b1, 1'b0, hs, hc}));
    end
    ordy = 1'b1;
    tick();
    chk("t3.idle", 64'({ov, ir, bz}), 64'b010);
    tick();
    chk("t3.nocap", 64'({ir, bz}), 64'b10);

    // reset in the middle of RUN
    iv = 1'b1; a = 8'hAA; b = 8'h55; c = 1'b0;
    tick();
    iv = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4.rst", 64'({ov, s, co, bz, ir}), 64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b1}));
    #2 rst_n = 1'b1;
    tick();
    op8(8'h0F, 8'hF0, 1'b1, "t4");

    // streaming random operands
    iv = 1'b1; ordy = 1'b1;
    got = 0; last = -1; cyc = 0;
    while (got < 1000 && cyc < 12000) begin
      if (ov) begin
        if (q.size() == 0) begin
          chk("t5.unexp", 64'({co, s}), 64'h1FF_FFFF);
        end else begin
          e = q.pop_front();
          chk("t5.res", 64'({co, s}), 64'(e));
        end
        got++;
      end
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      if (ir) begin
        if (last >= 0) chk("t5.ii", 64'(cyc - last), 64'd10);
        last = cyc;
        q.push_back(9'(a) + 9'(b) + 9'(c));
      end
      tick();
      cyc++;
    end
    iv = 1'b0;
    chk("t5.count", 64'(got), 64'd1000);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i);
      e = 9'(a1) + 9'(b1) + 9'(c1);
      iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      chk("t6.run", 64'({ov1, bz1}), 64'b01);
      tick();
      chk("t6.ov", 64'(ov1), 64'd1);
      chk("t6.res", 64'({co1, s1}), 64'(e));
      tick();
      chk("t6.idle", 64'({ov1, ir1}), 64'b01);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
